store_lane_packer: RTL and testbench
====================================

Name: store_lane_packer

Overview:
- Store-side counterpart of the load-path sign extender: narrows register data to byte/halfword/word.
- Replicates the narrowed value onto the correct byte lanes of the 32-bit data-memory bus and generates byte enables.
- Buffers stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Sits between the execute stage (store request) and the data memory write port.

Parameters:
DEPTH, 4, store buffer entries (power of 2, >=2)
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  store request present
req_ready  output  1  buffer can accept a request this cycle
req_addr  input  ADDR_W  byte address of store
req_data  input  32  register source data
req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
mem_valid  output  1  head entry valid toward memory
mem_ready  input  1  memory accepts head entry this cycle
mem_addr  output  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
mem_wdata  output  32  lane-replicated data
mem_be  output  4  byte enables, bit i = byte lane i (lane 0 = bits 7:0)
misalign_err  output  1  one-cycle pulse: last accepted request was dropped
count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n low, async): count=0, read/write pointers=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, misalign_err=0. req_ready=1 once reset deasserts.
- Accept: req_valid && req_ready at rising edge. req_ready = (count != DEPTH), combinational from count only; it does not depend on mem_ready, so no bypass when full.
- Packing, computed at accept:
  - byte: wdata = {4{data[7:0]}}; be = 4'b0001 << addr[1:0].
  - half: wdata = {2{data[15:0]}}; be = addr[1] ? 4'b1100 : 4'b0011.
  - word: wdata = data; be = 4'b1111.
  - Upper data bits beyond the store width are discarded, with no overflow or sign check.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - The request is consumed (handshake completes) but not enqueued.
  - misalign_err=1 for exactly the cycle after the accept edge, then 0.
  - Back-to-back bad requests hold misalign_err high each following cycle.
- Drain:
  - mem_valid = (count != 0).
  - mem_addr, mem_wdata and mem_be come from the head entry and are registered/array outputs, with no combinational path from req_*.
  - Head pops when mem_valid && mem_ready.
  - While mem_valid && !mem_ready, all mem_* outputs stay stable.
  - When count=0, mem_addr, mem_wdata and mem_be hold their last values but are don't-care; mem_be is driven 0.
- Latency: request accepted at edge N into an empty buffer appears with mem_valid=1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Count unchanged; both pointers advance.
  - When count=0 there is nothing to pop, so only the push applies.
  - When full, push is blocked by req_ready=0 and only the pop applies, so req_ready rises the cycle after the pop.
- Pointer wrap: pointers are log2(DEPTH) bits, wrap modulo DEPTH, and full/empty is resolved from count. Order is strict FIFO, with no merging or reordering.
- Reset mid-operation: all queued stores are discarded immediately, and mem_valid drops asynchronously.

Test Plan:
- After reset: count=0, mem_valid=0, req_ready=1. Then store byte data=0x12345678, addr=0x103 -> next cycle mem_addr=0x100, mem_wdata=0x78787878, mem_be=4'b1000.
- Store half data=0xFFFF8A3C, addr=0x202 -> mem_wdata=0x8A3C8A3C, mem_be=4'b1100, mem_addr=0x200. Store word 0xDEADBEEF at 0x10 -> be=4'b1111.
- Hold mem_ready=0 and push 5 stores -> req_ready falls after the 4th accept and count=4. Raise mem_ready for 1 cycle -> count=3 and req_ready=1 next cycle. Data drains in push order.
- Word at addr 0x102, then half at 0x201 -> misalign_err high for 1 cycle after each, count stays 0, mem_valid never rises.
- Steady stream with req_valid=mem_ready=1 for 10 cycles -> count stays at 1, one store retires per cycle, pointers wrap past DEPTH with the address sequence preserved.
- With 3 entries queued, pulse rst_n low mid-cycle -> mem_valid=0 and count=0 immediately, and no stale entry appears after reset release.

Source files
------------

// File: rtl/store_lane_packer_if.sv
// Store request bus (execute side) and data-memory write bus, bundled.
// The "master" modport is the environment around the packer (execute stage
// plus memory port); the "slave" modport is the packer itself.
interface store_lane_packer_if #(
  parameter int ADDR_W = 32
);
  // execute-stage store request
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  // data-memory write port
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_packer.sv
// Store lane packer: narrows register data to byte/half/word, replicates it
// onto the proper byte lanes with byte enables, and buffers the result in a
// small FIFO drained toward data memory over valid/ready.
module store_lane_packer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  store_lane_packer_if.slave       bus,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // FIFO storage, one slot per entry
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];
  logic [3:0]        be_mem   [DEPTH];

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          misalign_reg;

  logic [31:0]       pack_wdata;
  logic [3:0]        pack_be;
  logic [ADDR_W-1:0] pack_addr;
  logic              misaligned;
  logic              accept, push, pop;

  // Lane replication, byte-enable generation and alignment check for the
  // incoming request; bits above the store width are simply dropped.
  always_comb begin
    pack_wdata = bus.req_data;
    pack_be    = 4'b0000;
    misaligned = 1'b0;
    pack_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    case (bus.req_size)
      2'b00: begin
        pack_wdata = {4{bus.req_data[7:0]}};
        pack_be    = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        pack_wdata = {2{bus.req_data[15:0]}};
        pack_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        misaligned = bus.req_addr[0];
      end
      2'b10: begin
        pack_wdata = bus.req_data;
        pack_be    = 4'b1111;
        misaligned = (bus.req_addr[1:0] != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  // Handshakes: ready depends on occupancy only, so a full buffer never
  // accepts even when memory is draining in the same cycle. Misaligned
  // requests complete the handshake but never reach the FIFO.
  assign bus.req_ready = (count_reg != FULL_COUNT);
  assign bus.mem_valid = (count_reg != '0);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = accept && !misaligned;
  assign pop           = bus.mem_valid && bus.mem_ready;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (push) wr_ptr_next = wr_ptr_reg + PW'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer, occupancy and misalignment-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      misalign_reg <= accept && misaligned;
    end
  end

  // One storage slot per FIFO entry, written when the write pointer selects it.
  // Slots are cleared on reset so the head outputs read back as zero.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Capture the packed request into this slot on push.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          addr_mem[gi] <= '0;
          data_mem[gi] <= '0;
          be_mem[gi]   <= '0;
        end else if (push && (wr_ptr_reg == PW'(gi))) begin
          addr_mem[gi] <= pack_addr;
          data_mem[gi] <= pack_wdata;
          be_mem[gi]   <= pack_be;
        end
      end
    end
  endgenerate

  // Head entry drives memory straight from storage; the head slot cannot be
  // overwritten while it is valid, so outputs stay stable under back-pressure.
  assign bus.mem_addr  = addr_mem[rd_ptr_reg];
  assign bus.mem_wdata = data_mem[rd_ptr_reg];
  assign bus.mem_be    = bus.mem_valid ? be_mem[rd_ptr_reg] : 4'b0000;

  assign misalign_err  = misalign_reg;
  assign count         = count_reg;

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed bench for store_lane_packer: packing, back-pressure, misalignment,
// streaming with pointer wrap and mid-operation reset.
module tb_store_lane_packer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic       clk;
  logic       rst_n;
  logic       misalign_err;
  logic [2:0] count;

  int checks;
  int failures;

  store_lane_packer_if #(.ADDR_W(ADDR_W)) bus ();

  store_lane_packer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .misalign_err (misalign_err),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = s;
  endtask

  // push one store into an empty buffer, check the head, then pop it
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] s, input logic [31:0] ea,
                        input logic [31:0] ed, input logic [3:0] ebe);
    set_req(1'b1, a, d, s);
    step();
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    $display("store %s addr=0x%0h data=0x%0h size=%0d -> mem_addr=0x%0h wdata=0x%0h be=%b",
             tag, a, d, s, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    check({tag, "_valid"}, {31'b0, bus.mem_valid}, 32'd1);
    check({tag, "_addr"},  bus.mem_addr, ea);
    check({tag, "_wdata"}, bus.mem_wdata, ed);
    check({tag, "_be"},    {28'b0, bus.mem_be}, {28'b0, ebe});
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check({tag, "_drained"}, {29'b0, count}, 32'd0);
    check({tag, "_be_idle"}, {28'b0, bus.mem_be}, 32'd0);
  endtask

  // misaligned request: consumed, flagged for one cycle, never queued
  task automatic bad(input string tag, input logic [31:0] a, input logic [1:0] s);
    set_req(1'b1, a, 32'hCAFEF00D, s);
    step();
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    $display("bad store %s addr=0x%0h size=%0d -> misalign_err=%0b count=%0d",
             tag, a, s, misalign_err, count);
    check({tag, "_err"},   {31'b0, misalign_err}, 32'd1);
    check({tag, "_count"}, {29'b0, count}, 32'd0);
    check({tag, "_valid"}, {31'b0, bus.mem_valid}, 32'd0);
    step();
    check({tag, "_err_clr"}, {31'b0, misalign_err}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.mem_ready = 1'b0;
    set_req(1'b0, 32'h0, 32'h0, 2'b00);

    // reset state
    repeat (2) step();
    check("rst_count",    {29'b0, count}, 32'd0);
    check("rst_valid",    {31'b0, bus.mem_valid}, 32'd0);
    check("rst_be",       {28'b0, bus.mem_be}, 32'd0);
    check("rst_addr",     bus.mem_addr, 32'd0);
    check("rst_wdata",    bus.mem_wdata, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_ready",    {31'b0, bus.req_ready}, 32'd1);

    // lane packing
    single("byte103", 32'h103, 32'h12345678, 2'b00, 32'h100, 32'h78787878, 4'b1000);
    single("byte101", 32'h101, 32'hAABBCC5A, 2'b00, 32'h100, 32'h5A5A5A5A, 4'b0010);
    single("half202", 32'h202, 32'hFFFF8A3C, 2'b01, 32'h200, 32'h8A3C8A3C, 4'b1100);
    single("half200", 32'h200, 32'h00001234, 2'b01, 32'h200, 32'h12341234, 4'b0011);
    single("word010", 32'h010, 32'hDEADBEEF, 2'b10, 32'h010, 32'hDEADBEEF, 4'b1111);

    // fill under back-pressure: 4 accepted, 5th held off
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, 32'h400 + 32'(4 * i), 32'hA0 + 32'(i), 2'b10);
      step();
      $display("fill push %0d addr=0x%0h -> count=%0d req_ready=%0b",
               i, 32'h400 + 32'(4 * i), count, bus.req_ready);
    end
    check("full_count", {29'b0, count}, 32'd4);
    check("full_ready", {31'b0, bus.req_ready}, 32'd0);
    check("full_head",  bus.mem_addr, 32'h400);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    check("pop1_count", {29'b0, count}, 32'd3);
    check("pop1_ready", {31'b0, bus.req_ready}, 32'd1);
    check("pop1_head",  bus.mem_addr, 32'h404);
    step();  // held 5th request is accepted now
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    check("refill_count", {29'b0, count}, 32'd4);
    check("stall_head",   bus.mem_addr, 32'h404);
    for (int k = 1; k < 5; k++) begin
      $display("drain %0d addr=0x%0h data=0x%0h", k, bus.mem_addr, bus.mem_wdata);
      check("drain_addr",  bus.mem_addr, 32'h400 + 32'(4 * k));
      check("drain_wdata", bus.mem_wdata, 32'hA0 + 32'(k));
      bus.mem_ready = 1'b1;
      step();
    end
    bus.mem_ready = 1'b0;
    check("drain_count", {29'b0, count}, 32'd0);
    check("drain_valid", {31'b0, bus.mem_valid}, 32'd0);

    // misalignment
    bad("word102", 32'h102, 2'b10);
    bad("half201", 32'h201, 2'b01);
    // back-to-back bad requests keep the flag high
    set_req(1'b1, 32'h0, 32'h1, 2'b11);
    step();
    check("b2b_err1", {31'b0, misalign_err}, 32'd1);
    set_req(1'b1, 32'h1, 32'h1, 2'b10);
    step();
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    check("b2b_err2",   {31'b0, misalign_err}, 32'd1);
    check("b2b_count",  {29'b0, count}, 32'd0);
    step();
    check("b2b_clr",    {31'b0, misalign_err}, 32'd0);

    // steady stream, pointers wrap past DEPTH
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_req(1'b1, 32'h800 + 32'(4 * i), 32'(i), 2'b10);
      step();
      $display("stream %0d head addr=0x%0h count=%0d", i, bus.mem_addr, count);
      check("stream_count", {29'b0, count}, 32'd1);
      check("stream_head",  bus.mem_addr, 32'h800 + 32'(4 * i));
      check("stream_data",  bus.mem_wdata, 32'(i));
    end
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    step();
    bus.mem_ready = 1'b0;
    check("stream_end", {29'b0, count}, 32'd0);

    // reset mid-operation with 3 entries queued
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 32'hC00 + 32'(4 * i), 32'h55 + 32'(i), 2'b10);
      step();
    end
    set_req(1'b0, 32'h0, 32'h0, 2'b00);
    check("pre_rst_count", {29'b0, count}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-op reset -> mem_valid=%0b count=%0d", bus.mem_valid, count);
    check("async_rst_valid", {31'b0, bus.mem_valid}, 32'd0);
    check("async_rst_count", {29'b0, count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {31'b0, bus.mem_valid}, 32'd0);
    check("post_rst_be",    {28'b0, bus.mem_be}, 32'd0);
    single("post_rst", 32'hE04, 32'h0BADF00D, 2'b10, 32'hE04, 32'h0BADF00D, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
